// File: rtl/output_display.sv
//==============================================================================
// output_display : 4-digit multiplexed common-anode 7-segment driver for OUT.
// Optional decimal format via `define DECIMAL_MODE_EN.   Revision: 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module output_display #(
  parameter int REFRESH_DIV        = 100000,
  parameter bit LEADING_ZERO_BLANK = 1'b0
) (
  input  logic        CLK,
  input  logic        ACLR_L,
  input  logic [15:0] DATA_IN,
  output logic [6:0]  SEG_L,
  output logic        DP_L,
  output logic [3:0]  AN_L
);

  localparam int            CNT_W  = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      snap_q, snap_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             tc, load;
  logic [19:0]      disp, disp_sh;
  logic             blank;

  function automatic logic [6:0] seg_lut(input logic [3:0] nib);
    case (nib)
      4'h0: seg_lut = 7'h40;  4'h1: seg_lut = 7'h79;
      4'h2: seg_lut = 7'h24;  4'h3: seg_lut = 7'h30;
      4'h4: seg_lut = 7'h19;  4'h5: seg_lut = 7'h12;
      4'h6: seg_lut = 7'h02;  4'h7: seg_lut = 7'h78;
      4'h8: seg_lut = 7'h00;  4'h9: seg_lut = 7'h10;
      4'hA: seg_lut = 7'h08;  4'hB: seg_lut = 7'h03;
      4'hC: seg_lut = 7'h46;  4'hD: seg_lut = 7'h21;
      4'hE: seg_lut = 7'h06;  default: seg_lut = 7'h0E;
    endcase
  endfunction

  // Snapshot only at the frame wrap so all four digits come from one value
  always_comb begin
    tc     = (cnt_q == TC_VAL);
    load   = tc && (idx_q == 2'd3);
    cnt_d  = tc ? '0 : cnt_q + 1'b1;
    idx_d  = tc ? idx_q + 2'd1 : idx_q;
    snap_d = load ? DATA_IN : snap_q;
  end

`ifdef DECIMAL_MODE_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_t;

  conv_state_t state_q, state_d;
  logic [35:0] sr_q, sr_d;
  logic [3:0]  bit_q, bit_d;
  logic [19:0] res_q, res_d;
  logic [19:0] bcd_adj;
  logic        dp_q, dp_d;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bit_d   = bit_q;
    res_d   = res_q;
    bcd_adj = sr_q[35:16];
    for (int k = 0; k < 5; k++) begin
      if (bcd_adj[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_adj[4*k +: 4] + 4'd3;
    end
    case (state_q)
      ST_IDLE: ;
      ST_SHIFT: begin
        sr_d  = {bcd_adj, sr_q[15:0]} << 1;
        bit_d = bit_q + 4'd1;
        if (bit_q == 4'd15) state_d = ST_DONE;
      end
      ST_DONE: begin
        res_d   = sr_q[35:16];
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A fresh snapshot always wins, even mid-conversion
    if (load) begin
      state_d = ST_SHIFT;
      sr_d    = {20'd0, snap_d};
      bit_d   = 4'd0;
    end
  end

  always_ff @(posedge CLK or negedge ACLR_L) begin
    if (!ACLR_L) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      bit_q   <= '0;
      res_q   <= '0;
      dp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      res_q   <= res_d;
      dp_q    <= dp_d;
    end
  end

  always_comb begin
    disp = res_q;
    dp_d = !((idx_q == 2'd3) && (res_q[19:16] != 4'd0));
  end
  assign DP_L = dp_q;
`else
  always_comb disp = {4'd0, snap_q};
  assign DP_L = 1'b1;
`endif

  // A digit is blank when it and every digit above it (incl. overflow) are zero
  always_comb begin
    disp_sh = disp >> {idx_q, 2'b00};
    blank   = LEADING_ZERO_BLANK && (idx_q != 2'd0) && (disp_sh == 20'd0);
    seg_d   = blank ? 7'h7F : seg_lut(disp_sh[3:0]);
    an_d    = ~(4'b0001 << idx_q);
  end

  always_ff @(posedge CLK or negedge ACLR_L) begin
    if (!ACLR_L) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      snap_q <= '0;
      an_q   <= 4'b1110;
      seg_q  <= 7'h40;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign AN_L  = an_q;
  assign SEG_L = seg_q;

endmodule

`default_nettype wire
